// File: rtl/uart_bus_master.sv
// uart_bus_master: serial debug/loader bridge acting as a second bus master.
// Parses 'W' AH AL N D0..D(N-1) and 'R' AH AL N commands from the UART
// receiver, performs single-byte bus writes/reads, and returns read data
// through the UART transmitter. N=0 means 256 bytes.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   tx_data, tx_start     byte to transmit and its one-cycle start strobe
//   tx_busy               transmitter busy
//   bus_req, bus_gnt      bus ownership request / grant
//   addr, dbw, we         bus address, write data, write enable
//   dbr                   bus read data (valid one cycle after address)
module uart_bus_master #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] addr,
  output logic [7:0]  dbw,
  output logic        we,
  input  logic [7:0]  dbr
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE, S_AH, S_AL, S_LEN, S_WDATA, S_WBUS,
    S_RREQ, S_RCAP, S_RSEND, S_RWAIT, S_RBUSY
  } state_t;

  state_t        state, state_n;
  logic          is_wr, is_wr_n;
  logic [8:0]    count, count_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0]   addr_n;
  logic [7:0]    dbw_n, tx_data_n;
  logic          tx_start_n, bus_req_n;
  logic          timing, timeout;

  // Timer only runs while waiting for command/data bytes from the host.
  assign timing  = (state == S_AH) || (state == S_AL) || (state == S_LEN) || (state == S_WDATA);
  assign timeout = timing && !rx_valid && (timer == TW'(TIMEOUT - 1));

  // Write strobe is decoded from the access state and the live grant so it can
  // never be high without ownership, and drops at once on reset.
  assign we = (state == S_WBUS) && bus_req && bus_gnt;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      is_wr    <= 1'b0;
      count    <= '0;
      timer    <= '0;
      addr     <= '0;
      dbw      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      bus_req  <= 1'b0;
    end else begin
      state    <= state_n;
      is_wr    <= is_wr_n;
      count    <= count_n;
      timer    <= timer_n;
      addr     <= addr_n;
      dbw      <= dbw_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
      bus_req  <= bus_req_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    is_wr_n    = is_wr;
    count_n    = count;
    addr_n     = addr;
    dbw_n      = dbw;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    bus_req_n  = bus_req;
    timer_n    = (rx_valid || !timing) ? '0 : timer + TW'(1);

    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == CMD_W)) begin
          is_wr_n = 1'b1;
          state_n = S_AH;
        end else if (rx_valid && (rx_data == CMD_R)) begin
          is_wr_n = 1'b0;
          state_n = S_AH;
        end
      end
      S_AH: begin
        if (rx_valid) begin
          addr_n  = {rx_data, addr[7:0]};
          state_n = S_AL;
        end
      end
      S_AL: begin
        if (rx_valid) begin
          addr_n  = {addr[15:8], rx_data};
          state_n = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          count_n = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          if (is_wr) begin
            state_n = S_WDATA;
          end else begin
            bus_req_n = 1'b1;
            state_n   = S_RREQ;
          end
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          dbw_n     = rx_data;
          bus_req_n = 1'b1;
          state_n   = S_WBUS;
        end
      end
      S_WBUS: begin
        // The cycle with grant is the write cycle.
        if (bus_gnt) begin
          bus_req_n = 1'b0;
          addr_n    = addr + 16'd1;
          count_n   = count - 9'd1;
          state_n   = (count == 9'd1) ? S_IDLE : S_WDATA;
        end
      end
      S_RREQ: begin
        // The cycle with grant presents the read address.
        if (bus_gnt) state_n = S_RCAP;
      end
      S_RCAP: begin
        tx_data_n = dbr;
        bus_req_n = 1'b0;
        addr_n    = addr + 16'd1;
        state_n   = S_RSEND;
      end
      S_RSEND: begin
        if (!tx_busy) begin
          tx_start_n = 1'b1;
          state_n    = S_RWAIT;
        end
      end
      S_RWAIT: begin
        // Give the transmitter a cycle to raise busy.
        state_n = S_RBUSY;
      end
      S_RBUSY: begin
        if (!tx_busy) begin
          count_n = count - 9'd1;
          if (count == 9'd1) begin
            state_n = S_IDLE;
          end else begin
            bus_req_n = 1'b1;
            state_n   = S_RREQ;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (timeout) begin
      state_n   = S_IDLE;
      bus_req_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed + randomized bench for uart_bus_master with a
// memory/arbiter/transmitter environment and a command-level reference model.
module tb_uart_bus_master;

  localparam int unsigned TIMEOUT = 65535;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] addr;
  logic [7:0]  dbw;
  logic        we;
  logic [7:0]  dbr;

  uart_bus_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .addr(addr), .dbw(dbw),
    .we(we), .dbr(dbr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [7:0]  tx_q      [$];
  logic [7:0]  wbuf      [$];
  bit          force_low = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus slave memory, arbiter and transmitter environment.
  initial begin
    int          gnt_wait;
    int          busy_cnt;
    logic [7:0]  nxt_dbr;
    gnt_wait = 0;
    busy_cnt = 0;
    bus_gnt  = 1'b0;
    tx_busy  = 1'b0;
    dbr      = 8'h00;
    forever begin
      @(negedge clk);
      if (we) begin
        chk("we_without_grant", 32'(bus_req & bus_gnt), 32'd1);
        mem[addr] = dbw;
        wr_addr_q.push_back(addr);
        wr_data_q.push_back(dbw);
      end
      if (tx_start) begin
        chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
        tx_q.push_back(tx_data);
        busy_cnt = $urandom_range(1, 6);
      end
      // Read data appears only in the cycle after the address cycle.
      if (bus_req && bus_gnt && !we) nxt_dbr = mem[addr];
      else nxt_dbr = 8'($urandom);
      @(posedge clk);
      #1;
      dbr = nxt_dbr;
      if (!bus_req) begin
        bus_gnt  = 1'b0;
        gnt_wait = $urandom_range(0, 3);
      end else if (force_low || gnt_wait > 0) begin
        bus_gnt = 1'b0;
        if (!force_low) gnt_wait--;
      end else begin
        bus_gnt = 1'b1;
      end
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (wr_addr_q.size() < n && k < 20000) begin
      tick();
      k++;
    end
    repeat (4) tick();
    chk("write_count", 32'(wr_addr_q.size()), 32'(n));
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 20000) begin
      tick();
      k++;
    end
    repeat (10) tick();
    chk("tx_count", 32'(tx_q.size()), 32'(n));
  endtask

  // Write command from wbuf; expected writes are base+i (mod 2^16) with wbuf[i].
  task automatic do_write(input logic [15:0] a, input int gap);
    int n = wbuf.size();
    clear_logs();
    send(8'h57, 0);
    send(a[15:8], 0);
    send(a[7:0], 0);
    send(8'(n), 0);
    foreach (wbuf[i]) begin
      ref_mem[16'(a + 16'(i))] = wbuf[i];
      send(wbuf[i], gap);
    end
    wait_wr(n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk("write_addr", 32'(wr_addr_q[i]), 32'(16'(a + 16'(i))));
      chk("write_data", 32'(wr_data_q[i]), 32'(wbuf[i]));
    end
    chk("idle_bus_req", 32'(bus_req), 32'd0);
  endtask

  // Read command; expected tx stream is ref_mem[base+i] (mod 2^16).
  task automatic do_read(input logic [15:0] a, input int n);
    clear_logs();
    send(8'h52, 0);
    send(a[15:8], 0);
    send(a[7:0], 0);
    send(8'(n), 0);
    wait_tx(n);
    for (int i = 0; i < n && i < tx_q.size(); i++)
      chk("read_data", 32'(tx_q[i]), 32'(ref_mem[16'(a + 16'(i))]));
    chk("read_no_writes", 32'(wr_addr_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] a;
    int          n;
    int          k;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      b          = 8'($urandom);
      mem[i]     = b;
      ref_mem[i] = b;
    end
    repeat (3) tick();
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_dbw", 32'(dbw), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    rst = 1'b0;
    tick();

    // Two-byte write.
    wbuf = '{8'hAA, 8'h55};
    do_write(16'h1234, 10);
    chk("t1_mem_1234", 32'(mem[16'h1234]), 32'h0AA);
    chk("t1_mem_1235", 32'(mem[16'h1235]), 32'h055);

    // Read across the address wrap.
    mem[16'hFFFF] = 8'h11; ref_mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22; ref_mem[16'h0000] = 8'h22;
    do_read(16'hFFFF, 2);

    // N=0 means 256 bytes.
    wbuf.delete();
    for (int i = 0; i < 256; i++) wbuf.push_back(8'($urandom));
    do_write(16'h0010, 10);
    chk("t3_addr_after", 32'(addr), 32'h0110);

    // Grant withheld: request must hold, no write until granted.
    clear_logs();
    send(8'h57, 0); send(8'h20, 0); send(8'h00, 0); send(8'h01, 0);
    force_low = 1'b1;
    send(8'h5A, 1);
    for (int i = 0; i < 50; i++) begin
      chk("t4_req_held", 32'(bus_req), 32'd1);
      chk("t4_no_we", 32'(we), 32'd0);
      tick();
    end
    force_low = 1'b0;
    ref_mem[16'h2000] = 8'h5A;
    wait_wr(1);
    if (wr_addr_q.size() > 0) begin
      chk("t4_addr", 32'(wr_addr_q[0]), 32'h2000);
      chk("t4_data", 32'(wr_data_q[0]), 32'h05A);
    end

    // Abandoned command times out; next command parses from IDLE.
    clear_logs();
    send(8'h57, 0);
    send(8'h12, 0);
    repeat (TIMEOUT + 1) tick();
    chk("t5_bus_req", 32'(bus_req), 32'd0);
    do_read(16'h0000, 1);

    // Reset while the write strobe is high.
    clear_logs();
    send(8'h57, 0); send(8'h40, 0); send(8'h00, 0); send(8'h01, 0);
    force_low = 1'b1;
    send(8'h77, 0);
    k = 0;
    while (!bus_req && k < 20) begin tick(); k++; end
    force_low = 1'b0;
    k = 0;
    while (we !== 1'b1 && k < 20) begin tick(); k++; end
    chk("t6_we_high", 32'(we), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_we", 32'(we), 32'd0);
    chk("t6_bus_req", 32'(bus_req), 32'd0);
    chk("t6_tx_start", 32'(tx_start), 32'd0);
    chk("t6_addr", 32'(addr), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_no_write", 32'(wr_addr_q.size()), 32'd0);
    chk("t6_mem_kept", 32'(mem[16'h4000]), 32'(ref_mem[16'h4000]));
    do_read(16'h4000, 1);

    // Random command mix; non-command bytes in IDLE are ignored.
    for (int t = 0; t < 12; t++) begin
      a = 16'($urandom);
      n = $urandom_range(1, 6);
      send(8'h00, 0);
      if ($urandom_range(0, 1) == 1) begin
        wbuf.delete();
        for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
        do_write(a, 10);
      end else begin
        do_read(a, n);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
